// File: rtl/memory_responder_pkg.sv
// mem_pkg: shared widths and responder FSM state for the four-phase req/ack memory protocol.
// Contents: MEM_DATA_WIDTH, MEM_ADDR_WIDTH defaults; mem_resp_state_t {IDLE, WAIT, ACK}.
package mem_pkg;
    localparam int MEM_DATA_WIDTH = 256;
    localparam int MEM_ADDR_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} mem_resp_state_t;
endpackage

// File: rtl/memory_responder_if.sv
// memory_interface: req/ack handshake bundle between a memory master and a responder.
// Signals: req, w_en, addr (master -> slave); ack (slave -> master).
// The shared inout data bus is carried as a separate net beside this interface.
interface memory_interface
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
    logic                  req;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    modport master (output req, w_en, addr, input ack);
    modport slave  (input req, w_en, addr, output ack);
endinterface

// File: rtl/memory_responder_mem_array.sv
// mem_array: single-port synchronous RAM, DEPTH x DATA_WIDTH, one-cycle registered read, no reset.
// Ports: clk; we write strobe; re read strobe; addr word address; wdata write data; rdata registered read data.
module mem_array #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 1024,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/memory_responder.sv
// memory_responder: req/ack memory slave with fixed LATENCY, owning a mem_array and driving data on reads.
// Ports: clk; reset_n sync active-low; bus (memory_interface.slave: req, w_en, addr, ack); data inout bus.
// Optional: define MEM_RESPONDER_ASSERT_EN to compile in SVA protocol checks.
module memory_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    memory_interface.slave        bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int CW  = $clog2(LATENCY + 1);
    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_resp_state_t       state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic in_range;
    logic strobe;
    assign in_range = 32'(addr_q) < DEPTH;
    // Array access is issued in the last WAIT cycle so its registered read lands on the ACK entry edge.
    assign strobe   = state == WAIT && cnt == CW'(1) && in_range && reset_n;

    mem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(MAW)) u_mem (
        .clk   (clk),
        .we    (strobe && wen_q),
        .re    (strobe && !wen_q),
        .addr  (addr_q[MAW-1:0]),
        .wdata (wdata_q),
        .rdata (rdata_q)
    );

    assign data = (bus.ack && !wen_q) ? (in_range ? rdata_q : '0) : 'z;

    // cnt is loaded with LATENCY so that ACK is entered exactly LATENCY edges after acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bus.ack <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req) begin
                    state  <= WAIT;
                    cnt    <= CW'(LATENCY);
                    addr_q <= bus.addr;
                    wen_q  <= bus.w_en;
                    if (bus.w_en) wdata_q <= data;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state   <= ACK;
                        bus.ack <= 1'b1;
                    end
                end
                ACK: if (!bus.req) begin
                    state   <= IDLE;
                    bus.ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESPONDER_ASSERT_EN
    a_req_fall: assert property (@(posedge clk) disable iff (!reset_n) $fell(bus.req) |-> state == ACK)
        else $error("memory_responder: req dropped before ack (state=%s)", state.name());
    a_req_known: assert property (@(posedge clk) disable iff (!reset_n)
        (state == IDLE && bus.req) |-> !$isunknown({bus.addr, bus.w_en}))
        else $error("memory_responder: addr or w_en unknown when req accepted");
    a_ack_hold: assert property (@(posedge clk) disable iff (!reset_n) !(state == ACK && !bus.ack && !bus.req))
        else $error("memory_responder: ack and req both low while in ACK");
`else
`endif
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed self-checking bench for memory_responder at LATENCY=2 and LATENCY=3.
module tb_memory_responder;
    import mem_pkg::*;
    localparam int DW = MEM_DATA_WIDTH;
    localparam int AW = MEM_ADDR_WIDTH;
    localparam logic [DW-1:0] ZV  = {DW{1'b1}};
    localparam logic [DW-1:0] V0  = {8{32'h0123_4567}};
    localparam logic [DW-1:0] VA5 = {32{8'hA5}};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    memory_interface #(.ADDR_WIDTH(AW)) b2 ();
    memory_interface #(.ADDR_WIDTH(AW)) b3 ();
    wire  [DW-1:0] d2, d3;
    logic          m2_en = 1'b0, m3_en = 1'b0;
    logic [DW-1:0] m2_val = '0, m3_val = '0;
    assign d2 = m2_en ? m2_val : 'z;
    assign d3 = m3_en ? m3_val : 'z;
    // Undriven bus floats to all ones through the pull-ups, which is how high-Z is observed.
    for (genvar i = 0; i < DW; i++) begin : g_pu
        pullup (d2[i]);
        pullup (d3[i]);
    end

    memory_responder #(.LATENCY(2), .DEPTH(1024)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave), .data(d2));
    memory_responder #(.LATENCY(3), .DEPTH(1024)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave), .data(d3));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int u, input logic r, input logic w, input logic [AW-1:0] a);
        if (u == 2) begin
            b2.req = r; b2.w_en = w; b2.addr = a;
        end else begin
            b3.req = r; b3.w_en = w; b3.addr = a;
        end
    endtask

    task automatic drive(input int u, input logic en, input logic [DW-1:0] v);
        if (u == 2) begin
            m2_en = en; m2_val = v;
        end else begin
            m3_en = en; m3_val = v;
        end
    endtask

    function automatic logic get_ack(input int u);
        return (u == 2) ? b2.ack : b3.ack;
    endfunction

    function automatic logic [DW-1:0] get_data(input int u);
        return (u == 2) ? d2 : d3;
    endfunction

    // Full handshake: v is the write data, or the expected read data for a read.
    task automatic xact(input int u, input int lat, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] v, input string tag);
        set_bus(u, 1'b1, w, a);
        drive(u, w, v);
        tick;
        drive(u, 1'b0, '0);
        set_bus(u, 1'b1, w, ~a);
        chk({tag, " ack after accept"}, DW'(get_ack(u)), DW'(1'b0));
        for (int i = 1; i < lat; i++) begin
            tick;
            chk({tag, " ack in wait"}, DW'(get_ack(u)), DW'(1'b0));
        end
        tick;
        chk({tag, " ack at latency"}, DW'(get_ack(u)), DW'(1'b1));
        chk({tag, " data in ack"}, get_data(u), w ? ZV : v);
        set_bus(u, 1'b0, w, a);
        tick;
        chk({tag, " ack released"}, DW'(get_ack(u)), DW'(1'b0));
        chk({tag, " data idle"}, get_data(u), ZV);
    endtask

    initial begin
        set_bus(2, 1'b0, 1'b0, '0);
        set_bus(3, 1'b0, 1'b0, '0);
        tick;
        tick;
        chk("reset ack u2", DW'(b2.ack), DW'(1'b0));
        chk("reset ack u3", DW'(b3.ack), DW'(1'b0));
        chk("reset data u2", d2, ZV);
        reset_n = 1'b1;
        // First edge after release accepts a request.
        xact(2, 2, 1'b1, 16'd0, V0, "wr0");
        xact(2, 2, 1'b1, 16'd5, VA5, "wr5");
        xact(2, 2, 1'b0, 16'd5, VA5, "rd5");
        xact(2, 2, 1'b1, 16'd1024, ZV, "wr_oor");
        xact(2, 2, 1'b0, 16'd1024, '0, "rd_oor");
        xact(2, 2, 1'b0, 16'd0, V0, "rd0");
        xact(2, 2, 1'b1, 16'd1023, VA5 ^ V0, "wr_top");
        xact(2, 2, 1'b0, 16'd1023, VA5 ^ V0, "rd_top");
        // Reset during WAIT abandons the write.
        xact(2, 2, 1'b1, 16'd7, DW'(16'h55), "wr7_old");
        set_bus(2, 1'b1, 1'b1, 16'd7);
        drive(2, 1'b1, DW'(16'h1234));
        tick;
        drive(2, 1'b0, '0);
        reset_n = 1'b0;
        set_bus(2, 1'b0, 1'b0, '0);
        tick;
        chk("rst wait ack", DW'(b2.ack), DW'(1'b0));
        chk("rst wait data", d2, ZV);
        reset_n = 1'b1;
        tick;
        chk("rst wait no resume", DW'(b2.ack), DW'(1'b0));
        // Reset coinciding with the commit edge drops the write.
        set_bus(2, 1'b1, 1'b1, 16'd7);
        drive(2, 1'b1, DW'(16'h1234));
        tick;
        drive(2, 1'b0, '0);
        tick;
        reset_n = 1'b0;
        set_bus(2, 1'b0, 1'b0, '0);
        tick;
        chk("rst commit ack", DW'(b2.ack), DW'(1'b0));
        chk("rst commit data", d2, ZV);
        reset_n = 1'b1;
        xact(2, 2, 1'b0, 16'd7, DW'(16'h55), "rd7");
        // Early req drop in WAIT: transaction completes with a single-cycle ack.
        set_bus(2, 1'b1, 1'b0, 16'd5);
        tick;
        set_bus(2, 1'b0, 1'b0, 16'd5);
        chk("early ack0", DW'(b2.ack), DW'(1'b0));
        tick;
        chk("early ack1", DW'(b2.ack), DW'(1'b0));
        tick;
        chk("early ack2", DW'(b2.ack), DW'(1'b1));
        chk("early data", d2, VA5);
        tick;
        chk("early ack3", DW'(b2.ack), DW'(1'b0));
        chk("early data idle", d2, ZV);
        tick;
        chk("early ack4", DW'(b2.ack), DW'(1'b0));
        // Back-to-back at LATENCY=3: each next req is raised right after ack falls.
        for (int i = 0; i < 4; i++)
            xact(3, 3, 1'b1, AW'(10 + i), {32{8'(8'h11 * (i + 1))}}, "b2b_wr");
        for (int i = 0; i < 4; i++)
            xact(3, 3, 1'b0, AW'(10 + i), {32{8'(8'h11 * (i + 1))}}, "b2b_rd");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
